// File: rtl/subc_sequencer.sv
// Frame-level sub-frame scheduler: counts pattern words per fill, waits for FIFO drain,
// times exposure windows and advances CntSubc. Optional stall watchdog: SUBC_TIMEOUT_EN.
module subc_sequencer #(
    parameter int C_NUM_ROWS  = 160,
    parameter int EXP_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      Num_Pat,
    input  logic [EXP_W-1:0] Exp_Cyc,
    input  logic             pat_wr,
    input  logic             pat_fifo_empty,
    input  logic             readout_ack,
    output logic [31:0]      CntSubc,
    output logic             subc_expose,
    output logic             frame_busy,
    output logic             readout_req,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam int                WPS    = C_NUM_ROWS * 18;
    localparam int                WCNT_W = $clog2(WPS + 1);
    localparam logic [WCNT_W-1:0] WPS_V  = WCNT_W'(WPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_DRAIN,
        S_EXPOSE,
        S_READ
    } state_t;

    typedef enum logic [1:0] {
        PH_FIRST,
        PH_PATS,
        PH_LAST
    } phase_t;

    state_t            state, state_nxt;
    phase_t            phase, phase_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [WCNT_W-1:0] wr_inc;
    logic [WCNT_W-1:0] wcnt_acc;
    logic [EXP_W-1:0]  ecnt, ecnt_nxt;
    logic [EXP_W-1:0]  exp_lat, exp_lat_nxt;
    logic [31:0]       np_lat, np_lat_nxt;
    logic [31:0]       cnt_nxt;
    logic [31:0]       cnt_inc;
    logic              empty_p1;
    logic              done_nxt;
    logic              abort;

    assign wr_inc  = WCNT_W'(pat_wr);
    assign cnt_inc = CntSubc + 32'd1;
    // Outside a fill, words still accumulate toward the next fill but never pass WPS.
    assign wcnt_acc = (wcnt == WPS_V) ? wcnt : wcnt + wr_inc;

`ifdef SUBC_TIMEOUT_EN
    localparam logic [31:0] TO_V = 32'(TIMEOUT_CYC);

    logic [31:0] stall;
    logic        stall_cyc;
    logic        terr;

    assign stall_cyc = ((state == S_FIRST) && (wcnt != WPS_V) && !pat_wr) ||
                       ((state == S_DRAIN) && !empty_p1);
    assign abort       = stall_cyc && (stall == TO_V - 32'd1);
    assign timeout_err = terr;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall <= '0;
            terr  <= 1'b0;
        end else begin
            if (abort) terr <= 1'b1;
            stall <= (stall_cyc && !abort) ? stall + 32'd1 : '0;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign abort              = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        wcnt_nxt    = wcnt;
        ecnt_nxt    = ecnt;
        exp_lat_nxt = exp_lat;
        np_lat_nxt  = np_lat;
        cnt_nxt     = CntSubc;
        done_nxt    = 1'b0;
        subc_expose = 1'b0;
        frame_busy  = 1'b1;
        readout_req = 1'b0;

        case (state)
            S_IDLE: begin
                frame_busy = 1'b0;
                if (start) begin
                    np_lat_nxt  = Num_Pat;
                    exp_lat_nxt = (Exp_Cyc == '0) ? EXP_W'(1) : Exp_Cyc;
                    cnt_nxt     = '0;
                    wcnt_nxt    = '0;
                    phase_nxt   = PH_FIRST;
                    state_nxt   = S_FIRST;
                end
            end
            S_FIRST: begin
                // A word arriving on the completion cycle belongs to the next fill.
                if (wcnt == WPS_V) begin
                    wcnt_nxt  = wr_inc;
                    state_nxt = S_DRAIN;
                end else begin
                    wcnt_nxt = wcnt + wr_inc;
                end
            end
            S_DRAIN: begin
                wcnt_nxt = wcnt_acc;
                if (empty_p1) begin
                    case (phase)
                        PH_FIRST: begin
                            phase_nxt = (np_lat == 32'd0) ? PH_LAST : PH_PATS;
                            state_nxt = S_FIRST;
                        end
                        PH_PATS: begin
                            ecnt_nxt  = exp_lat;
                            state_nxt = S_EXPOSE;
                        end
                        default: state_nxt = S_READ;
                    endcase
                end
            end
            S_EXPOSE: begin
                subc_expose = 1'b1;
                wcnt_nxt    = wcnt_acc;
                ecnt_nxt    = ecnt - EXP_W'(1);
                if (ecnt == EXP_W'(1)) begin
                    cnt_nxt   = cnt_inc;
                    phase_nxt = (cnt_inc == np_lat) ? PH_LAST : PH_PATS;
                    state_nxt = S_FIRST;
                end
            end
            S_READ: begin
                readout_req = 1'b1;
                wcnt_nxt    = wcnt_acc;
                if (readout_ack) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            wcnt_nxt  = '0;
            ecnt_nxt  = '0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= PH_FIRST;
            wcnt       <= '0;
            ecnt       <= '0;
            CntSubc    <= '0;
            empty_p1   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            wcnt       <= wcnt_nxt;
            ecnt       <= ecnt_nxt;
            CntSubc    <= cnt_nxt;
            empty_p1   <= pat_fifo_empty;
            frame_done <= done_nxt;
        end
    end

    // Frame configuration is only sampled on an accepted start, so it needs no reset.
    always_ff @(posedge clk) begin
        np_lat  <= np_lat_nxt;
        exp_lat <= exp_lat_nxt;
    end

endmodule

// File: tb/tb_subc_sequencer.sv
// Bench for subc_sequencer: randomized frames checked every cycle against a
// sub-frame-index reference model, plus frame-level totals.
module tb_subc_sequencer;

    localparam int WPS = 2880;
    localparam int TO  = 100;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_EXP   = 3;
    localparam int M_READ  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] Num_Pat = '0;
    logic [15:0] Exp_Cyc = '0;
    logic        pat_wr = 1'b0;
    logic        pat_fifo_empty = 1'b0;
    logic        readout_ack = 1'b0;
    logic [31:0] CntSubc;
    logic        subc_expose;
    logic        frame_busy;
    logic        readout_req;
    logic        frame_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: m_sf is the sub-frame index (0 first, 1..Np exposed, Np+1 last).
    int m_mode, m_sf, m_words, m_left, m_exp, m_np, m_cnt, m_stall;
    bit m_done, m_terr, m_emp_q;

    int st_exp_cycles, st_windows, st_done, st_req;
    bit prev_exp;

    subc_sequencer #(
        .C_NUM_ROWS (160),
        .EXP_W      (16),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .Num_Pat       (Num_Pat),
        .Exp_Cyc       (Exp_Cyc),
        .pat_wr        (pat_wr),
        .pat_fifo_empty(pat_fifo_empty),
        .readout_ack   (readout_ack),
        .CntSubc       (CntSubc),
        .subc_expose   (subc_expose),
        .frame_busy    (frame_busy),
        .readout_req   (readout_req),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic model_step(input bit r, input bit st, input bit wr, input bit emp, input bit ack);
        bit stalled;
        m_done = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_sf = 0; m_words = 0; m_left = 0; m_cnt = 0;
            m_stall = 0; m_terr = 1'b0; m_emp_q = 1'b0;
            return;
        end
        stalled = ((m_mode == M_FILL) && (m_words != WPS) && !wr) ||
                  ((m_mode == M_DRAIN) && !m_emp_q);
`ifdef SUBC_TIMEOUT_EN
        if (stalled && (m_stall + 1 >= TO)) begin
            m_terr = 1'b1; m_mode = M_IDLE; m_cnt = 0; m_words = 0; m_stall = 0;
            m_emp_q = emp;
            return;
        end
        m_stall = stalled ? m_stall + 1 : 0;
`else
        if (stalled) m_stall = 0;
`endif
        case (m_mode)
            M_IDLE: if (st) begin
                m_np = int'(Num_Pat);
                m_exp = (Exp_Cyc == 0) ? 1 : int'(Exp_Cyc);
                m_cnt = 0; m_words = 0; m_sf = 0; m_mode = M_FILL;
            end
            M_FILL: begin
                if (m_words == WPS) begin
                    m_words = int'(wr);
                    m_mode = M_DRAIN;
                end else m_words += int'(wr);
            end
            M_DRAIN: begin
                if (m_words < WPS) m_words += int'(wr);
                if (m_emp_q) begin
                    if (m_sf == 0) begin m_sf = 1; m_mode = M_FILL; end
                    else if (m_sf <= m_np) begin m_left = m_exp; m_mode = M_EXP; end
                    else m_mode = M_READ;
                end
            end
            M_EXP: begin
                if (m_words < WPS) m_words += int'(wr);
                m_left--;
                if (m_left == 0) begin m_cnt++; m_sf++; m_mode = M_FILL; end
            end
            default: begin
                if (m_words < WPS) m_words += int'(wr);
                if (ack) begin m_done = 1'b1; m_mode = M_IDLE; end
            end
        endcase
        m_emp_q = emp;
    endtask

    task automatic cyc(input bit r, input bit st, input bit wr, input bit emp, input bit ack);
        @(negedge clk);
        rst = r; start = st; pat_wr = wr; pat_fifo_empty = emp; readout_ack = ack;
        @(posedge clk);
        model_step(r, st, wr, emp, ack);
        #1;
        chk("CntSubc", CntSubc, m_cnt);
        chk("subc_expose", subc_expose, m_mode == M_EXP);
        chk("frame_busy", frame_busy, m_mode != M_IDLE);
        chk("readout_req", readout_req, m_mode == M_READ);
        chk("frame_done", frame_done, m_done);
        chk("timeout_err", timeout_err, m_terr);
        if (subc_expose) st_exp_cycles++;
        if (subc_expose && !prev_exp) st_windows++;
        prev_exp = subc_expose;
        if (frame_done) st_done++;
        if (readout_req) st_req++;
    endtask

    task automatic begin_frame(input int np, input int ex);
        Num_Pat = np; Exp_Cyc = ex;
        st_exp_cycles = 0; st_windows = 0; st_done = 0; st_req = 0;
        cyc(0, 1, 1, 1, 0);
    endtask

    // Runs a whole frame; configuration inputs are scrambled mid-frame and must be ignored.
    task automatic run_frame(input int np, input int ex, input int dens, input int emp_pct,
                             input int ack_pct, input int st_pct);
        begin_frame(np, ex);
        for (int i = 0; i < 30000 && m_mode != M_IDLE; i++) begin
            Num_Pat = $urandom_range(9);
            Exp_Cyc = 16'($urandom_range(30));
            cyc(0, pct(st_pct), pct(dens), pct(emp_pct), pct(ack_pct));
        end
        chk("frame_ended", frame_busy, 0);
        chk("cnt_final", CntSubc, np);
        chk("expose_cycles", st_exp_cycles, np * ((ex == 0) ? 1 : ex));
        chk("expose_windows", st_windows, np);
        chk("done_pulses", st_done, 1);
        chk("req_seen", st_req > 0, 1);
    endtask

    initial begin
        int np, ex;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        chk("rst_cnt", CntSubc, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_req", readout_req, 0);
        cyc(0, 0, 1, 1, 1);

        // Continuous pat_wr across fill boundaries, two 4-cycle windows.
        run_frame(2, 4, 100, 100, 30, 0);
        // No exposed sub-frames.
        run_frame(0, 5, 100, 100, 30, 0);
        // Zero exposure clamps to a single cycle; gappy writes and slow drain.
        run_frame(1, 0, 80, 60, 25, 5);

        // Reset during the first exposure window, with stray starts mid-frame.
        begin_frame(3, 6);
        for (int i = 0; i < 20000 && !(m_mode == M_EXP && m_left == 3); i++)
            cyc(0, pct(10), 1, 1, 0);
        chk("pre_rst_expose", subc_expose, 1);
        cyc(1, 0, 1, 1, 1);
        chk("post_rst_cnt", CntSubc, 0);
        chk("post_rst_expose", subc_expose, 0);
        chk("post_rst_busy", frame_busy, 0);
        chk("post_rst_done", frame_done, 0);
        cyc(0, 0, 1, 1, 1);
        chk("no_done_after_rst", frame_done, 0);
        run_frame(1, 3, 100, 100, 50, 10);

        // Randomized frame.
        np = $urandom_range(1, 2);
        ex = $urandom_range(0, 20);
        run_frame(np, ex, $urandom_range(75, 100), $urandom_range(50, 95), 30, 5);

        // FIFO never drains after the first fill.
        begin_frame(1, 2);
        for (int i = 0; i < 10000 && m_mode != M_DRAIN; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 120; i++) cyc(0, 0, 0, 0, 0);
`ifdef SUBC_TIMEOUT_EN
        chk("to_err", timeout_err, 1);
        chk("to_busy", frame_busy, 0);
        chk("to_cnt", CntSubc, 0);
        chk("to_no_done", st_done, 0);
        cyc(1, 0, 0, 0, 0);
        chk("to_cleared", timeout_err, 0);
`else
        chk("stall_busy", frame_busy, 1);
        chk("stall_err", timeout_err, 0);
        chk("stall_no_expose", st_exp_cycles, 0);
        for (int i = 0; i < 30000 && m_mode != M_IDLE; i++) cyc(0, 0, 1, 1, 1);
        chk("stall_recovered", frame_busy, 0);
        chk("stall_cnt", CntSubc, 1);
        chk("stall_done", st_done, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
